// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the key input conditioner.
//   - default parameter values
//   - FSM state encoding (2-bit)
//   - is_onehot helper
package key_pkg;

  localparam int NUM_KEYS_DEF          = 4;
  localparam int DEBOUNCE_CYCLES_DEF   = 50000;
  localparam int LONG_PRESS_CYCLES_DEF = 100000000;

  localparam logic [1:0] ST_IDLE             = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE_PRESS   = 2'd1;
  localparam logic [1:0] ST_PRESSED          = 2'd2;
  localparam logic [1:0] ST_DEBOUNCE_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    IDLE             = ST_IDLE,
    DEBOUNCE_PRESS   = ST_DEBOUNCE_PRESS,
    PRESSED          = ST_PRESSED,
    DEBOUNCE_RELEASE = ST_DEBOUNCE_RELEASE
  } key_state_t;

  // Exactly one bit set (zero is not one-hot).
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/key_input_conditioner_sync.sv
// sync_2ff: parameterised-width two-flop synchroniser.
//   clock  : sampling clock
//   reset  : async active-low, both stages load RST_VAL
//   d      : asynchronous input
//   q      : synchronised output (two cycles of latency)
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_input_conditioner.sv
// key_input_conditioner: synchronises and debounces active-low push-buttons
// and emits one single-cycle one-hot key event per clean press. A full
// debounced release is required before the next event.
//   clock      : system clock
//   reset      : async active-low reset
//   key_n      : raw buttons, active-low, asynchronous
//   key        : one-hot event pulse (one cycle per accepted press)
//   key_held   : high while a debounced press is in progress
//   multi_key  : one-cycle pulse when a multi-key pattern is accepted
//   long_press : one-cycle pulse after a long one-hot hold
// Optional feature macro: KEY_LONG_PRESS_EN (long_press tied 0 when undefined).
module key_input_conditioner
  import key_pkg::*;
#(
  parameter int NUM_KEYS          = NUM_KEYS_DEF,
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key,
  output logic                key_held,
  output logic                multi_key,
  output logic                long_press
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ? DEBOUNCE_CYCLES
                                                                 : LONG_PRESS_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);
`ifdef KEY_LONG_PRESS_EN
  localparam logic [CW-1:0] LP_LAST = CW'(LONG_PRESS_CYCLES - 1);
`endif

  logic [NUM_KEYS-1:0] key_s, pressed;
  logic [NUM_KEYS-1:0] cap, cap_nx, key_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic                multi_nx;
  key_state_t          state, state_nx;

  // Released buttons read as 1, so the synchroniser resets to all ones.
  sync_2ff #(.WIDTH(NUM_KEYS), .RST_VAL({NUM_KEYS{1'b1}})) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (key_n),
    .q     (key_s)
  );

  assign pressed = ~key_s;

`ifdef KEY_LONG_PRESS_EN
  logic long_nx;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cap_nx   = cap;
    key_nx   = '0;
    multi_nx = 1'b0;
`ifdef KEY_LONG_PRESS_EN
    long_nx  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (pressed != '0) begin
          cap_nx   = pressed;
          cnt_nx   = '0;
          state_nx = DEBOUNCE_PRESS;
        end
      end
      DEBOUNCE_PRESS: begin
        if (pressed != cap) begin
          state_nx = IDLE;
        end else if (cnt == DB_LAST) begin
          state_nx = PRESSED;
          if (is_onehot(32'(cap))) key_nx   = cap;
          else                     multi_nx = 1'b1;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      PRESSED: begin
        if (pressed == '0) begin
          cnt_nx   = '0;
          state_nx = DEBOUNCE_RELEASE;
        end
`ifdef KEY_LONG_PRESS_EN
        // Any pattern change parks the counter at its terminal value, which
        // both stops the count and blocks a later long_press.
        else if (pressed != cap) begin
          cnt_nx = LP_LAST;
        end else if (is_onehot(32'(cap)) && cnt < LP_LAST) begin
          cnt_nx = cnt + ONE;
          if (cnt + ONE == LP_LAST) long_nx = 1'b1;
        end
`endif
      end
      DEBOUNCE_RELEASE: begin
        if (pressed != '0) begin
          state_nx = PRESSED;
`ifdef KEY_LONG_PRESS_EN
          cnt_nx   = LP_LAST;
`endif
        end else if (cnt == DB_LAST) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      cap       <= '0;
      key       <= '0;
      multi_key <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      cap       <= cap_nx;
      key       <= key_nx;
      multi_key <= multi_nx;
      key_held  <= (state_nx == PRESSED) || (state_nx == DEBOUNCE_RELEASE);
    end
  end

`ifdef KEY_LONG_PRESS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) long_press <= 1'b0;
    else        long_press <= long_nx;
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_key_input_conditioner.sv
// Testbench for key_input_conditioner: directed scenarios plus randomized
// button patterns, checked every cycle against a window/run-length model.
module tb_key_input_conditioner;

  localparam int NK = 4;
  localparam int D  = 4;
  localparam int L  = 20;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key;
  logic          key_held, multi_key, long_press;

  int nchk = 0, nerr = 0;
  int ev_key = 0, ev_multi = 0, ev_long = 0;

  key_input_conditioner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)
  ) dut (
    .clock(clock), .reset(reset), .key_n(key_n), .key(key),
    .key_held(key_held), .multi_key(multi_key), .long_press(long_press)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit onehot(input logic [NK-1:0] v);
    return $countones(v) == 1;
  endfunction

  // Reference model: sampled pattern is key_n delayed two edges. A press is
  // accepted once the same nonzero pattern is seen on D+1 consecutive edges
  // (counting from the edge where it was first picked up while idle). A press
  // ends once D+1 consecutive all-released edges follow acceptance.
  logic [NK-1:0] ms1 = '0, ms2 = '0, cand = '0;
  int            clen = 0, zrun = 0;
  bit            busy = 0;
  logic [NK-1:0] e_key;
  bit            e_multi, e_long;
`ifdef KEY_LONG_PRESS_EN
  logic [NK-1:0] cap_m = '0;
  bit            lp_live = 0;
  int            lp_run = 0;
`endif

  always begin
    logic [NK-1:0] p;
    @(posedge clock);
    #1;
    e_key = '0; e_multi = 0; e_long = 0;
    if (!reset) begin
      ms1 = '0; ms2 = '0; cand = '0; busy = 0; clen = 0; zrun = 0;
`ifdef KEY_LONG_PRESS_EN
      lp_live = 0;
`endif
    end else begin
      p   = ms2;
      ms2 = ms1;
      ms1 = ~key_n;
      if (busy) begin
        zrun = (p == '0) ? zrun + 1 : 0;
`ifdef KEY_LONG_PRESS_EN
        if (lp_live) begin
          if (p == cap_m) begin
            lp_run++;
            if (lp_run == L - D) begin e_long = 1; lp_live = 0; end
          end else lp_live = 0;
        end
`endif
        if (zrun == D + 1) busy = 0;
      end else if (cand != '0) begin
        if (p != cand) cand = '0;
        else begin
          clen++;
          if (clen == D + 1) begin
            if (onehot(cand)) e_key = cand;
            else              e_multi = 1;
            busy = 1; zrun = 0;
`ifdef KEY_LONG_PRESS_EN
            cap_m = cand; lp_live = onehot(cand); lp_run = 0;
`endif
            cand = '0;
          end
        end
      end else if (p != '0) begin
        cand = p; clen = 1;
      end
    end
    chk("key", 32'(key), 32'(e_key));
    chk("multi_key", 32'(multi_key), 32'(e_multi));
    chk("key_held", 32'(key_held), 32'(busy));
    chk("long_press", 32'(long_press), 32'(e_long));
    if (key != '0) ev_key++;
    if (multi_key)  ev_multi++;
    if (long_press) ev_long++;
  end

  task automatic hold(input logic [NK-1:0] v, input int n);
    repeat (n) begin
      @(negedge clock);
      key_n = v;
    end
  endtask

  initial begin
    int n, got, pulses, sk, sm, sl;
    logic [NK-1:0] v;

    // Reset held with a key down: outputs stay cleared.
    reset = 0; key_n = 4'b1110;
    repeat (5) @(negedge clock);
    chk("rst_key", 32'(key), 0);
    chk("rst_held", 32'(key_held), 0);
    chk("rst_multi", 32'(multi_key), 0);
    reset = 1; key_n = '1;
    hold('1, 3);

    // Exact latency of the first press.
    @(negedge clock) key_n = 4'b1110;
    got = 0; pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      if (key == 4'b0001) begin pulses++; if (got == 0) got = i; end
    end
    chk("latency", got, 7);
    chk("latency_pulses", pulses, 1);
    hold('1, 12);

    // Clean press of key 2.
    sk = ev_key;
    hold(4'b1011, 30); hold('1, 10);
    chk("clean_events", ev_key - sk, 1);

    // Press bounce.
    sk = ev_key;
    repeat (5) begin hold(4'b1110, 2); hold('1, 2); end
    hold(4'b1110, 15); hold('1, 10);
    chk("bounce_events", ev_key - sk, 1);

    // Multi-key, partial release, then a single key.
    sk = ev_key; sm = ev_multi;
    hold(4'b1100, 15); hold(4'b1101, 10); hold('1, 10);
    chk("multi_events", ev_multi - sm, 1);
    chk("multi_no_key", ev_key - sk, 0);
    hold(4'b0111, 15); hold('1, 10);
    chk("after_multi_key", ev_key - sk, 1);

    // Release glitch.
    sk = ev_key;
    hold(4'b1110, 15); hold('1, 2); hold(4'b1110, 1); hold('1, 12);
    chk("release_bounce", ev_key - sk, 1);

    // Reset mid-debounce with the key still held.
    sk = ev_key;
    hold(4'b1110, 4);
    @(negedge clock) reset = 0;
    repeat (2) @(negedge clock);
    reset = 1;
    hold(4'b1110, 15); hold('1, 10);
    chk("reset_mid_press", ev_key - sk, 1);

    // Long hold.
    sk = ev_key; sl = ev_long;
    hold(4'b1101, 40); hold('1, 10);
    chk("long_key", ev_key - sk, 1);
`ifdef KEY_LONG_PRESS_EN
    chk("long_events", ev_long - sl, 1);
`else
    chk("long_events", ev_long - sl, 0);
`endif

    // Random patterns.
    for (int s = 0; s < 300; s++) begin
      n = $urandom_range(0, 9);
      if (n < 4)      v = '1;
      else if (n < 8) v = ~(NK'(1) << $urandom_range(0, NK - 1));
      else            v = NK'($urandom_range(0, 15));
      hold(v, $urandom_range(1, 10));
    end
    hold('1, 12);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/key_input_conditioner.md
Name: key_input_conditioner

Overview:
- Sits directly upstream of the DigitalLock top level, between the raw DE1-SoC push-buttons and the lock's key[3:0] input.
- Synchronises and debounces the active-low raw buttons.
- Emits exactly one single-cycle, one-hot key event per clean press.
- Requires a full release before the next event, so the lock FSM sees one event per press and no bounce or multi-key noise.

Parameters:
- NUM_KEYS, 4: number of push-buttons handled.
- DEBOUNCE_CYCLES, 50000: clock cycles an input pattern must hold stable to be accepted (1 ms at 50 MHz); must be ≥2.
- LONG_PRESS_CYCLES, 100000000: PRESSED-state hold cycles before long_press fires; used only with LONG_PRESS_EN.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- key_n  input  NUM_KEYS  raw board buttons, active-low (0 = pressed), asynchronous to clock.
- key  output  NUM_KEYS  one-hot event pulse to the lock; high for exactly one cycle per accepted press.
- key_held  output  1  high while a debounced press is in progress (PRESSED or DEBOUNCE_RELEASE).
- multi_key  output  1  one-cycle pulse when a debounced pattern with more than one key is accepted.
- long_press  output  1  one-cycle pulse; see Optional Feature; tied 0 when the feature is disabled.

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-low. All flops clear immediately on reset low.
- Reset values:
  - key = 0, key_held = 0, multi_key = 0, long_press = 0.
  - Synchroniser flops = "released" (active-high internal value 0).
  - state = IDLE, counter = 0.
- Synchroniser and compare:
  - key_n passes through a 2-flop synchroniser, then is inverted to active-high `pressed[NUM_KEYS-1:0]`.
  - cap: register holding the pattern captured on entry to DEBOUNCE_PRESS.
  - counter width: $clog2(max(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES)+1). Counter saturates and never wraps.
- FSM states: IDLE, DEBOUNCE_PRESS, PRESSED, DEBOUNCE_RELEASE.
  - IDLE: when pressed != 0, set cap <= pressed, counter <= 0, go to DEBOUNCE_PRESS.
  - DEBOUNCE_PRESS:
    - pressed != cap (bounce, or key added/removed): return to IDLE with no output.
    - Otherwise increment counter.
    - When counter == DEBOUNCE_CYCLES-1 and the pattern is still equal, go to PRESSED and on the same edge:
      - cap one-hot: key <= cap for one cycle.
      - cap multi-bit: key stays 0 and multi_key pulses.
  - PRESSED:
    - Extra keys pressed or partial release: ignored, no events.
    - pressed == 0: counter <= 0, go to DEBOUNCE_RELEASE.
  - DEBOUNCE_RELEASE:
    - Any pressed != 0: back to PRESSED; no new event is generated.
    - counter == DEBOUNCE_CYCLES-1 with all keys released: go to IDLE.
- Latency: a press held stable from synchroniser input edge N produces key high in the cycle after edge N+DEBOUNCE_CYCLES+2. That cycle is fixed; the bench checks it exactly.
- key_held = (state == PRESSED || state == DEBOUNCE_RELEASE), registered.
- key and multi_key are never high in the same cycle; at most one event per press/release cycle.
- Reset asserted mid-debounce or mid-press: the in-flight event is discarded. After reset release with a key still held, the press is re-debounced from IDLE and does produce one event.

Optional Feature:
- Macro: KEY_LONG_PRESS_EN.
- Defined:
  - counter keeps counting in PRESSED (from the entry value) while the pattern stays equal to a one-hot cap.
  - On reaching LONG_PRESS_CYCLES-1, long_press pulses once; counter saturates, so there is no repeat.
  - Any pattern change in PRESSED stops the count without firing.
- Not defined: long_press is tied 0 and PRESSED performs no counting; behaviour is otherwise identical.

Decomposition:
- Shared package (key_pkg):
  - FSM state encoding localparams (2-bit): IDLE=0, DEBOUNCE_PRESS=1, PRESSED=2, DEBOUNCE_RELEASE=3.
  - Default NUM_KEYS and DEBOUNCE_CYCLES constants.
  - is_onehot function.
- One natural sub-module: sync_2ff (parameterised-width two-flop synchroniser with active-low async reset to a parameter value). The FSM and counter stay in the top.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, NUM_KEYS=4.
- Reset: reset=0 with key_n=4'b1110 → key=0, key_held=0, multi_key=0. After release, holding key_n=4'b1110 → key=4'b0001 for exactly one cycle, 7 edges after the first sampled press.
- Clean press of key 2 (key_n=4'b1011), held 30 cycles, then released 10 cycles → exactly one key=4'b0100 pulse; key_held high from the pulse cycle until release debounce completes.
- Bounce: key_n toggles 1110/1111 every 2 cycles for 20 cycles, then holds 1110 → a single key=4'b0001 pulse, timed from the last stable edge.
- Multi-key: key_n=4'b1100 stable → multi_key pulses once, key stays 0. Dropping to 1101 while held → no event. Full release then press 0111 → key=4'b1000.
- Release bounce: hold 1110, release with a 1-cycle re-press glitch → no second pulse; IDLE reached 4 cycles after the final release.
- KEY_LONG_PRESS_EN: hold 1101 for 40 cycles → one key=4'b0010 pulse plus one long_press pulse, no repeat. Without the macro, long_press stays 0.
